// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
// Shared constants for the instruction sequencer front-end:
//   - opcode values understood by the downstream control FSM
//   - bit offsets of the fields inside the 10-bit instruction word
//   - the step-0 state code that also signals "instruction finished"
//   - the sequencer phase enum
// No ports (package).
// -----------------------------------------------------------------------------
package instr_seq_pkg;

    // Opcodes (func field). The sequencer never decodes them; they are kept
    // here so the rest of the processor shares one definition.
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_MOVE = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    // instr_word = {func[3:0], rx[2:0], ry[2:0]}
    localparam int WORD_W   = 10;
    localparam int FUNC_W   = 4;
    localparam int REG_W    = 3;
    localparam int FUNC_LSB = 6;
    localparam int RX_LSB   = 3;
    localparam int RY_LSB   = 0;

    // Step 0 of every instruction; next_state == STEP0 marks the retire cycle.
    localparam logic [4:0] STEP0 = 5'b00000;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } phase_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
// Valid/ready instruction transfer channel into the sequencer.
//   instr_valid  master -> slave   an instruction is offered
//   instr_ready  slave  -> master  queue can accept
//   instr_word   master -> slave   {func[3:0], rx[2:0], ry[2:0]}
//   instr_data   master -> slave   load immediate, DATA_W bits
// A transfer happens on a rising edge where instr_valid && instr_ready.
// -----------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [9:0]        instr_word;
    logic [DATA_W-1:0] instr_data;

    modport master (
        output instr_valid,
        output instr_word,
        output instr_data,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_word,
        input  instr_data,
        output instr_ready
    );
endinterface

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Synchronous FIFO with full/empty flags. Pointers carry one extra wrap bit so
// full and empty are distinguished without an occupancy counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers only)
//   push, wdata  write request and data (accepted when not full, or when full
//                and popping in the same cycle)
//   pop, rdata   read request; rdata shows the head entry combinationally
//   full, empty  status flags
// DEPTH must be a power of 2 and at least 2.
// -----------------------------------------------------------------------------
module instr_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so push-while-full is safe then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Front-end of the simple processor. Queues instructions, presents the
// executing one to the control FSM (func/input1/input2/din) and owns the
// current_state register that the FSM advances via next_state. An instruction
// retires on the cycle the FSM returns next_state == 0; the next queued
// instruction starts at step 0 on the following cycle with no bubble.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   up             instruction channel (instr_sequencer_if.slave)
//   next_state     next-state from the control FSM
//   current_state  registered step code to the control FSM
//   func/input1/input2/din  fields of the executing instruction (0 when idle)
//   busy           an instruction is executing
//   done           retire pulse (combinational from next_state and phase)
//   illegal        with done when retiring straight from step 0
//   retire_count   16-bit wrapping retire counter, only when the macro
//                  INSTR_SEQ_RETIRE_CNT_EN is defined
// -----------------------------------------------------------------------------
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_sequencer_if.slave  up,
    input  logic [4:0]        next_state,
    output logic [4:0]        current_state,
    output logic [3:0]        func,
    output logic [2:0]        input1,
    output logic [2:0]        input2,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              illegal
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]       retire_count
`endif
);
    localparam int ENTRY_W = WORD_W + DATA_W;

    phase_t              phase;
    phase_t              phase_nxt;
    logic [WORD_W-1:0]   ir_word;
    logic [DATA_W-1:0]   ir_data;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                ir_load;
    logic                ir_clear;

    assign up.instr_ready = !fifo_full;
    assign fifo_push      = up.instr_valid && !fifo_full;

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({up.instr_word, up.instr_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= IDLE;
        else        phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = phase;
        fifo_pop  = 1'b0;
        ir_load   = 1'b0;
        ir_clear  = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (phase)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    ir_load   = 1'b1;
                    phase_nxt = EXEC;
                end
            end
            EXEC: begin
                if (next_state == STEP0) begin
                    done    = 1'b1;
                    // The FSM only retires from step 0 when it did not know the opcode.
                    illegal = (current_state == STEP0);
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        ir_load  = 1'b1;
                    end else begin
                        ir_clear  = 1'b1;
                        phase_nxt = IDLE;
                    end
                end
            end
            default: phase_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_word <= '0;
            ir_data <= '0;
        end else if (ir_load) begin
            {ir_word, ir_data} <= fifo_rdata;
        end else if (ir_clear) begin
            ir_word <= '0;
            ir_data <= '0;
        end
    end

    // Each new instruction starts at step 0; otherwise follow the FSM while executing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= STEP0;
        end else if (ir_load || ir_clear) begin
            current_state <= STEP0;
        end else if (phase == EXEC) begin
            current_state <= next_state;
        end
    end

    assign func   = ir_word[FUNC_LSB +: FUNC_W];
    assign input1 = ir_word[RX_LSB +: REG_W];
    assign input2 = ir_word[RY_LSB +: REG_W];
    assign din    = ir_data;
    assign busy   = (phase == EXEC);

`ifdef INSTR_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    retire_count <= '0;
        else if (done) retire_count <= retire_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Bench for instr_sequencer. A behavioural control FSM answers next_state
// from a per-opcode step table; a queue-based reference model predicts the
// sequencer outputs every cycle. Directed cases are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [9:0]        w;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic [4:0]        next_state;
    logic [4:0]        current_state;
    logic [3:0]        func;
    logic [2:0]        input1;
    logic [2:0]        input2;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;
    logic              illegal;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [15:0]       retire_count;
`endif

    instr_sequencer_if #(.DATA_W(DATA_W)) up_if ();

    instr_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .up            (up_if),
        .next_state    (next_state),
        .current_state (current_state),
        .func          (func),
        .input1        (input1),
        .input2        (input2),
        .din           (din),
        .busy          (busy),
        .done          (done),
        .illegal       (illegal)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step table of the control FSM, including step 0; the last entry is the
    // state in which next_state == 0 (retire).
    function automatic int nsteps(input logic [3:0] op);
        case (op)
            4'd1, 4'd2:                   return 2;
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7: return 4;
            default:                      return 1;
        endcase
    endfunction

    function automatic logic [4:0] step_at(input logic [3:0] op, input int k);
        if (k == 0) return 5'd0;
        case (op)
            4'd1:    return 5'd1;
            4'd2:    return 5'd2;
            4'd3:    return 5'(2 + k);
            4'd4:    return 5'(6 + k);
            4'd5:    return 5'(9 + k);
            4'd6:    return 5'(12 + k);
            4'd7:    return 5'(15 + k);
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] ctrl_next(input logic [3:0] op, input logic [4:0] cs);
        for (int k = 0; k < nsteps(op); k++) begin
            if (step_at(op, k) == cs) return (k + 1 < nsteps(op)) ? step_at(op, k + 1) : 5'd0;
        end
        return 5'd0;
    endfunction

    assign next_state = ctrl_next(func, current_state);

    // Reference model state
    ent_t mq[$];       // instructions held in the queue
    ent_t stim[$];     // instructions waiting to be offered
    ent_t cur;
    bit   cur_v;
    int   idx;
    int   rcnt;
    int   valid_pct;

    task automatic model_clear();
        mq.delete();
        stim.delete();
        cur   = '0;
        cur_v = 0;
        idx   = 0;
        rcnt  = 0;
    endtask

    // Called at a falling edge: drive inputs, check outputs, advance one clock.
    task automatic run_cycle();
        bit         push;
        bit         pop;
        bit         dn;
        logic [3:0] op;
        if (stim.size() > 0 && $urandom_range(99) < valid_pct) begin
            up_if.instr_valid = 1'b1;
            up_if.instr_word  = stim[0].w;
            up_if.instr_data  = stim[0].d;
        end else begin
            up_if.instr_valid = 1'b0;
            up_if.instr_word  = 10'($urandom);
            up_if.instr_data  = DATA_W'($urandom);
        end
        #1;
        op = cur_v ? cur.w[9:6] : 4'd0;
        dn = cur_v && (idx == nsteps(op) - 1);
        chk("busy",    32'(busy),          32'(cur_v));
        chk("func",    32'(func),          32'(op));
        chk("input1",  32'(input1),        cur_v ? 32'(cur.w[5:3]) : 32'd0);
        chk("input2",  32'(input2),        cur_v ? 32'(cur.w[2:0]) : 32'd0);
        chk("din",     32'(din),           cur_v ? 32'(cur.d) : 32'd0);
        chk("cstate",  32'(current_state), cur_v ? 32'(step_at(op, idx)) : 32'd0);
        chk("done",    32'(done),          32'(dn));
        chk("illegal", 32'(illegal),       32'(dn && nsteps(op) == 1));
        chk("ready",   32'(up_if.instr_ready), 32'(mq.size() < DEPTH));
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        chk("rcount",  32'(retire_count),  32'(rcnt & 16'hFFFF));
`endif
        push = up_if.instr_valid && (mq.size() < DEPTH);
        pop  = (!cur_v || dn) && (mq.size() > 0);
        @(posedge clk);
        if (dn) begin
            rcnt++;
            cur_v = 0;
            cur   = '0;
        end
        if (pop) begin
            cur   = mq.pop_front();
            idx   = 0;
            cur_v = 1;
        end else if (cur_v) begin
            idx++;
        end
        if (push) mq.push_back(stim.pop_front());
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int budget = 200;
        while ((stim.size() > 0 || mq.size() > 0 || cur_v) && budget > 0) begin
            run_cycle();
            budget--;
        end
        run_cycle();
        chk({tag, "_timeout"}, 32'(budget > 0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},   32'(busy),          32'd0);
        chk({tag, "_func"},   32'(func),          32'd0);
        chk({tag, "_in1"},    32'(input1),        32'd0);
        chk({tag, "_in2"},    32'(input2),        32'd0);
        chk({tag, "_din"},    32'(din),           32'd0);
        chk({tag, "_cstate"}, 32'(current_state), 32'd0);
        chk({tag, "_done"},   32'(done),          32'd0);
        chk({tag, "_ill"},    32'(illegal),       32'd0);
        chk({tag, "_ready"},  32'(up_if.instr_ready), 32'd1);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        chk({tag, "_rcount"}, 32'(retire_count),  32'd0);
`endif
    endtask

    function automatic ent_t rand_instr();
        ent_t       e;
        int         r;
        logic [3:0] op;
        r = $urandom_range(9);
        if (r <= 6)      op = 4'(r + 1);
        else if (r == 7) op = 4'd0;
        else             op = 4'($urandom_range(15, 8));
        e.w = {op, 3'($urandom), 3'($urandom)};
        e.d = DATA_W'($urandom);
        return e;
    endfunction

    initial begin
        int budget;
        rst_n             = 1'b0;
        up_if.instr_valid = 1'b0;
        up_if.instr_word  = '0;
        up_if.instr_data  = '0;
        valid_pct         = 100;
        model_clear();
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // load, add, back-to-back move/sub, illegal
        stim.push_back('{w: 10'b0001_010_000, d: 8'hA5});
        drain("load");
        stim.push_back('{w: 10'b0011_001_011, d: 8'h3C});
        drain("add");
        stim.push_back('{w: 10'b0010_100_001, d: 8'h11});
        stim.push_back('{w: 10'b0100_110_010, d: 8'h22});
        drain("b2b");
        stim.push_back('{w: 10'b1111_000_000, d: 8'h00});
        drain("illegal");

        // full queue: one executing plus five offered back-to-back
        for (int i = 0; i < 6; i++)
            stim.push_back('{w: {4'b0011, 3'(i), 3'(7 - i)}, d: 8'(8'h40 + i)});
        drain("full");

        // random traffic
        valid_pct = 70;
        for (int i = 0; i < 60; i++) stim.push_back(rand_instr());
        drain("rand");

        // reset while add sits at step 4
        valid_pct = 100;
        stim.push_back('{w: 10'b0011_101_010, d: 8'h5A});
        budget = 20;
        while (!(cur_v && cur.w[9:6] == 4'd3 && idx == 2) && budget > 0) begin
            run_cycle();
            budget--;
        end
        chk("rst_wait_timeout", 32'(budget > 0), 32'd1);
        chk("rst_pre_cstate", 32'(current_state), 32'd4);
        #2;
        rst_n             = 1'b0;
        up_if.instr_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        @(posedge clk);
        #1;
        chk("midrst_done_edge", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal operation resumes after reset
        stim.push_back('{w: 10'b0001_011_000, d: 8'hC3});
        stim.push_back('{w: 10'b0111_001_001, d: 8'h7E});
        drain("post");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
